// File: rtl/uart_cfg.sv
// uart_cfg: parametrised full-duplex UART (baud divisor, 5..8 data bits, parity, stop bits).
// TX and RX run independently; RX reports parity, framing and overrun per completed frame.
module uart_cfg #(
    parameter int BAUD_DIV  = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_rdy,
    input  logic                 clr_rx_rdy,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_ovr
);
    localparam int CW    = $clog2(BAUD_DIV);
    localparam int PB    = (PARITY != 0) ? 1 : 0;
    localparam int FRAME = 1 + DATA_BITS + PB + STOP_BITS;
    localparam int BW    = $clog2(FRAME);
    localparam int RBW   = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~^d : ^d;
    endfunction

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    tx_state_t        tx_state;
    logic [CW-1:0]    tx_cnt;
    logic [BW-1:0]    tx_bit;
    logic [FRAME-2:0] tx_frame;
    logic [FRAME-2:0] tx_shift;
    logic             tx_tick, tx_last, tx_load;

    // Everything after the start bit: data LSB first, optional parity, stop bits as 1s.
    always_comb begin
        tx_frame = '1;
        tx_frame[DATA_BITS-1:0] = tx_data;
        if (PARITY != 0) tx_frame[DATA_BITS] = par_of(tx_data);
    end

    assign tx_tick = (tx_state == TX_SEND) && (tx_cnt == BIT_END);
    assign tx_last = tx_tick && (tx_bit == BW'(FRAME - 1));
    assign tx_load = trmt && ((tx_state == TX_IDLE) || tx_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
            TX       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else if (tx_load) begin
            tx_state <= TX_SEND;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= tx_frame;
            TX       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_done  <= 1'b0;
        end else if (tx_last) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            TX       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
        end else if (tx_tick) begin
            tx_cnt   <= '0;
            tx_bit   <= tx_bit + BW'(1);
            TX       <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[FRAME-2:1]};
        end else if (tx_state == TX_SEND) begin
            tx_cnt <= tx_cnt + CW'(1);
        end
    end

    rx_state_t            rx_state;
    logic                 rx_s1, rx_s2, rx_armed, rx_par;
    logic [CW-1:0]        rx_cnt;
    logic [RBW-1:0]       rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
        end
    end

    assign rx_tick = (rx_cnt == BIT_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_armed <= 1'b1;
            rx_par   <= 1'b0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            if (clr_rx_rdy) begin
                rx_rdy <= 1'b0;
                rx_ovr <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    // after a break the line must go idle before the next start counts
                    if (rx_s2) rx_armed <= 1'b1;
                    else if (rx_armed) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else rx_cnt <= rx_cnt + CW'(1);
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        rx_bit   <= rx_bit + RBW'(1);
                        if (rx_bit == RBW'(DATA_BITS - 1))
                            rx_state <= (PARITY != 0) ? RX_PAR : RX_STOP;
                    end else rx_cnt <= rx_cnt + CW'(1);
                end
                RX_PAR: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_s2;
                        rx_state <= RX_STOP;
                    end else rx_cnt <= rx_cnt + CW'(1);
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        rx_armed <= rx_s2;
                        rx_data  <= rx_shift;
                        rx_ferr  <= ~rx_s2;
                        rx_perr  <= (PARITY != 0) && (rx_par != par_of(rx_shift));
                        rx_rdy   <= 1'b1;
                        rx_ovr   <= !clr_rx_rdy && (rx_ovr || rx_rdy);
                    end else rx_cnt <= rx_cnt + CW'(1);
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: a default 8N1 instance and a fast 7O2 instance, checked with vector
// tables, hand-timed corner sequences and randomized frames against a bit-level frame model.
module tb_uart_cfg;
    localparam int B0 = 434;
    localparam int B1 = 16;

    typedef struct packed {
        logic tx, busy, done, rdy, perr, ferr, ovr;
        logic [7:0] d;
    } stat_t;
    typedef struct { logic [7:0] d; bit poke; } lbvec_t;
    typedef struct { logic [7:0] d; bit flip; bit bad; logic [7:0] xd; logic xp; logic xf; } rxvec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic trmt0 = 1'b0, trmt1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;
    logic loop0 = 1'b0, loop1 = 1'b0, drv0 = 1'b1, drv1 = 1'b1;
    logic [7:0] txd0 = '0;
    logic [6:0] txd1 = '0;
    logic tx0, busy0, done0, rdy0, perr0, ferr0, ovr0;
    logic tx1, busy1, done1, rdy1, perr1, ferr1, ovr1;
    logic [7:0] rxd0;
    logic [6:0] rxd1;
    logic rxin0, rxin1;
    assign rxin0 = loop0 ? tx0 : drv0;
    assign rxin1 = loop1 ? tx1 : drv1;

    int checks = 0;
    int passes = 0;

    uart_cfg u0 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt0), .tx_data(txd0), .TX(tx0), .tx_busy(busy0),
        .tx_done(done0), .RX(rxin0), .rx_data(rxd0), .rx_rdy(rdy0), .clr_rx_rdy(clr0),
        .rx_perr(perr0), .rx_ferr(ferr0), .rx_ovr(ovr0)
    );

    uart_cfg #(.BAUD_DIV(B1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt1), .tx_data(txd1), .TX(tx1), .tx_busy(busy1),
        .tx_done(done1), .RX(rxin1), .rx_data(rxd1), .rx_rdy(rdy1), .clr_rx_rdy(clr1),
        .rx_perr(perr1), .rx_ferr(ferr1), .rx_ovr(ovr1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic stat_t st(input int w);
        stat_t s;
        if (w == 0) s = '{tx0, busy0, done0, rdy0, perr0, ferr0, ovr0, rxd0};
        else        s = '{tx1, busy1, done1, rdy1, perr1, ferr1, ovr1, {1'b0, rxd1}};
        return s;
    endfunction

    task automatic set_trmt(input int w, input logic v, input logic [7:0] d);
        if (w == 0) begin trmt0 = v; txd0 = d; end
        else begin trmt1 = v; txd1 = d[6:0]; end
    endtask

    task automatic set_drv(input int w, input logic v);
        if (w == 0) drv0 = v; else drv1 = v;
    endtask

    task automatic pulse_clr(input int w);
        @(negedge clk);
        if (w == 0) clr0 = 1'b1; else clr1 = 1'b1;
        @(negedge clk);
        if (w == 0) clr0 = 1'b0; else clr1 = 1'b0;
    endtask

    // Serial frame as a bit list: start, data LSB first, odd parity on instance 1, stop bits.
    function automatic int mk_frame(input int w, input logic [7:0] d, input bit flip,
                                    input bit bad, output logic [15:0] f);
        int db;
        int n;
        db = (w == 0) ? 8 : 7;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < db; i++) f[1 + i] = d[i];
        n = 1 + db;
        if (w != 0) begin
            f[n] = ((($countones(d[6:0]) % 2) == 0) ? 1'b1 : 1'b0) ^ flip;
            n++;
        end
        if (bad) f[n] = 1'b0;
        return n + ((w == 0) ? 1 : 2);
    endfunction

    task automatic drive_rx(input int w, input logic [15:0] f, input int n);
        int b;
        b = (w == 0) ? B0 : B1;
        for (int k = 0; k < n; k++) begin
            set_drv(w, f[k]);
            repeat (b) @(negedge clk);
        end
        set_drv(w, 1'b1);
    endtask

    // Sends one frame and compares TX/tx_busy every cycle against the modelled bit list.
    task automatic send_tx(input int w, input logic [7:0] d, input bit poke, input string tag);
        logic [15:0] f;
        int n, b, errs, done_at;
        stat_t s;
        n = mk_frame(w, d, 1'b0, 1'b0, f);
        b = (w == 0) ? B0 : B1;
        errs = 0;
        done_at = -1;
        @(negedge clk); set_trmt(w, 1'b1, d);
        @(negedge clk); set_trmt(w, 1'b0, d);
        for (int c = 0; c <= n * b + 2; c++) begin
            s = st(w);
            if (s.tx !== ((c < n * b) ? f[c / b] : 1'b1)) errs++;
            if (s.busy !== (c < n * b)) errs++;
            if (s.done === 1'b1 && done_at < 0) done_at = c;
            if (poke) set_trmt(w, c == 3 * b, ~d);
            @(negedge clk);
        end
        chk({tag, "_wave_errs"}, errs, 0);
        chk({tag, "_done_at"}, done_at, n * b);
    endtask

    task automatic check_rx(input int w, input string tag, input logic [7:0] xd,
                            input logic xp, input logic xf, input logic xo);
        stat_t s;
        int n;
        n = 0;
        s = st(w);
        while (s.rdy !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
            s = st(w);
        end
        chk({tag, "_rdy"}, s.rdy, 1);
        chk({tag, "_data"}, s.d, xd);
        chk({tag, "_perr"}, s.perr, xp);
        chk({tag, "_ferr"}, s.ferr, xf);
        chk({tag, "_ovr"}, s.ovr, xo);
    endtask

    initial begin
        lbvec_t lv[4];
        rxvec_t rv[4];
        stat_t s, rst_exp;
        logic [15:0] f;
        int n, hits;
        logic [7:0] d;
        bit use_tx, do_clr, flip, bad;
        logic m_rdy, m_ovr, xp, xf;

        lv[0] = '{8'h00, 1'b0};
        lv[1] = '{8'hFF, 1'b0};
        lv[2] = '{8'h3C, 1'b0};
        lv[3] = '{8'h96, 1'b1};
        rv[0] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0};
        rv[1] = '{8'h2A, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b0};
        rv[2] = '{8'h7F, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1};
        rv[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1};
        rst_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        repeat (3) @(negedge clk);
        chk("reset_u0", st(0), rst_exp);
        chk("reset_u1", st(1), rst_exp);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_tx(0, 8'hA5, 1'b0, "a5");

        loop0 = 1'b1;
        foreach (lv[i]) begin
            send_tx(0, lv[i].d, lv[i].poke, $sformatf("lb%0d", i));
            check_rx(0, $sformatf("lb%0d", i), lv[i].d, 1'b0, 1'b0, 1'b0);
            pulse_clr(0);
            s = st(0);
            chk("lb_clr_rdy", s.rdy, 0);
        end
        loop0 = 1'b0;

        set_drv(0, 1'b0);
        repeat (100) @(negedge clk);
        set_drv(0, 1'b1);
        repeat (2 * B0) @(negedge clk);
        s = st(0);
        chk("false_start_rdy", s.rdy, 0);
        n = mk_frame(0, 8'h12, 1'b0, 1'b0, f);
        drive_rx(0, f, n);
        check_rx(0, "after_false", 8'h12, 1'b0, 1'b0, 1'b0);
        pulse_clr(0);

        foreach (rv[i]) begin
            n = mk_frame(1, rv[i].d, rv[i].flip, rv[i].bad, f);
            drive_rx(1, f, n);
            check_rx(1, $sformatf("rxv%0d", i), rv[i].xd, rv[i].xp, rv[i].xf, 1'b0);
            pulse_clr(1);
        end

        n = mk_frame(1, 8'h11, 1'b0, 1'b0, f);
        drive_rx(1, f, n);
        n = mk_frame(1, 8'h22, 1'b0, 1'b0, f);
        drive_rx(1, f, n);
        check_rx(1, "ovr", 8'h22, 1'b0, 1'b0, 1'b1);
        pulse_clr(1);
        s = st(1);
        chk("ovr_clr_rdy", s.rdy, 0);
        chk("ovr_clr_ovr", s.ovr, 0);

        // clr held across a whole frame: completion must still show rx_rdy for one cycle
        n = mk_frame(1, 8'h44, 1'b0, 1'b0, f);
        @(negedge clk); clr1 = 1'b1;
        hits = 0;
        for (int k = 0; k < n; k++) begin
            drv1 = f[k];
            repeat (B1) begin
                @(negedge clk);
                if (rdy1 === 1'b1) hits++;
            end
        end
        drv1 = 1'b1;
        clr1 = 1'b0;
        chk("set_wins_hits", hits, 1);
        s = st(1);
        chk("set_wins_data", s.d, 8'h44);
        chk("set_wins_ovr", s.ovr, 0);

        set_drv(1, 1'b0);
        repeat (12 * B1) @(negedge clk);
        check_rx(1, "break", 8'h00, 1'b1, 1'b1, 1'b0);
        pulse_clr(1);
        repeat (12 * B1) @(negedge clk);
        s = st(1);
        chk("break_single", s.rdy, 0);
        set_drv(1, 1'b1);
        repeat (B1) @(negedge clk);
        n = mk_frame(1, 8'h33, 1'b0, 1'b0, f);
        drive_rx(1, f, n);
        check_rx(1, "rearm", 8'h33, 1'b0, 1'b0, 1'b0);
        pulse_clr(1);

        m_rdy = 1'b0;
        m_ovr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 127));
            use_tx = ($urandom_range(0, 2) == 0);
            do_clr = ($urandom_range(0, 1) == 1);
            if (do_clr) begin
                pulse_clr(1);
                m_rdy = 1'b0;
                m_ovr = 1'b0;
            end
            if (use_tx) begin
                loop1 = 1'b1;
                send_tx(1, d, ($urandom_range(0, 1) == 1), $sformatf("rtx%0d", i));
                loop1 = 1'b0;
                xp = 1'b0;
                xf = 1'b0;
            end else begin
                flip = ($urandom_range(0, 3) == 0);
                bad = ($urandom_range(0, 3) == 0);
                n = mk_frame(1, d, flip, bad, f);
                drive_rx(1, f, n);
                xp = flip;
                xf = bad;
            end
            m_ovr = m_ovr | m_rdy;
            m_rdy = 1'b1;
            check_rx(1, $sformatf("rnd%0d", i), d, xp, xf, m_ovr);
            repeat ($urandom_range(1, 20)) @(negedge clk);
        end

        @(negedge clk); set_trmt(0, 1'b1, 8'h00);
        @(negedge clk); set_trmt(0, 1'b0, 8'h00);
        repeat (1000) @(negedge clk);
        s = st(0);
        chk("pre_rst_tx", s.tx, 0);
        chk("pre_rst_busy", s.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        s = st(0);
        chk("async_rst_tx", s.tx, 1);
        chk("async_rst_busy", s.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        s = st(0);
        chk("post_rst_done", s.done, 0);
        chk("post_rst_tx", s.tx, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
